// File: rtl/hazard_mul_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use stalls, branch flushes, multi-cycle multiply sequencing and a stall counter.
module hazard_mul_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic             memToRegE,
    input  logic [3:0]       ALUControlE,
    input  logic             branchTakenE,
    input  logic [4:0]       writeRegM,
    input  logic             regWriteM,
    input  logic [4:0]       writeRegW,
    input  logic             regWriteW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mulBusy,
    output logic             mulDone,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [7:0] CNT_INIT = (MUL_CYCLES > 2) ? 8'(MUL_CYCLES - 3) : 8'd0;

    state_t          state_r, state_next_s;
    logic [7:0]      cnt_r, cnt_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [1:0]      fwd_a_s, fwd_b_s;
    logic            mul_e_s, mul_stall_s, lw_stall_s;
    logic            stall_f_s, stall_d_s, stall_e_s;
    logic            flush_d_s, flush_e_s, flush_m_s, mul_busy_s, mul_done_s;

    // MEM stage wins over WB; register $0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       rw_m, input logic [4:0] wr_m,
                                           input logic       rw_w, input logic [4:0] wr_w);
        if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
            return 2'b10;
        end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Forwarding selects and hazard detection terms.
    always_comb begin
        fwd_a_s     = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
        fwd_b_s     = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
        mul_e_s     = (ALUControlE == 4'b1111);
        mul_stall_s = ((state_r == ST_IDLE) && mul_e_s) || (state_r == ST_BUSY);
        lw_stall_s  = memToRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
    end

    // Multiply FSM next state plus prioritised stall/flush generation.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        stall_f_s    = 1'b0;
        stall_d_s    = 1'b0;
        stall_e_s    = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        flush_m_s    = 1'b0;
        mul_busy_s   = 1'b0;
        mul_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mul_e_s) begin
                    if (MUL_CYCLES == 2) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                        cnt_next_s   = CNT_INIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            ST_DONE: begin
                // mulE here is still the finishing multiply, so it must not retrigger.
                mul_done_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase

        if (mul_stall_s) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e_s  = 1'b1;
            flush_m_s  = 1'b1;
            mul_busy_s = 1'b1;
        end else if (branchTakenE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lw_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // FSM state and multiply countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign forwardAE  = rst_n ? fwd_a_s : 2'b00;
    assign forwardBE  = rst_n ? fwd_b_s : 2'b00;
    assign stallF     = rst_n & stall_f_s;
    assign stallD     = rst_n & stall_d_s;
    assign stallE     = rst_n & stall_e_s;
    assign flushD     = rst_n & flush_d_s;
    assign flushE     = rst_n & flush_e_s & ~stall_e_s;
    assign flushM     = rst_n & flush_m_s;
    assign mulBusy    = rst_n & mul_busy_s;
    assign mulDone    = rst_n & mul_done_s;
    assign stallCount = rst_n ? stall_cnt_r : {CNT_W{1'b0}};

endmodule

// File: tb/tb_hazard_mul_controller.sv
// Directed bench: vector table for forwarding/load-use/branch, hand sequences for multiply and reset.
module tb_hazard_mul_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rsD = 5'd0, rtD = 5'd0, rsE = 5'd0, rtE = 5'd0;
    logic        memToRegE = 1'b0, branchTakenE = 1'b0;
    logic [3:0]  alu4 = 4'd0, alu2 = 4'd0;
    logic [4:0]  writeRegM = 5'd0, writeRegW = 5'd0;
    logic        regWriteM = 1'b0, regWriteW = 1'b0;

    logic [1:0]  fa4, fb4, fa2, fb2;
    logic        sf4, sd4, se4, fd4, fe4, fm4, mb4, md4;
    logic        sf2, sd2, se2, fd2, fe2, fm2, mb2, md2;
    logic [15:0] cnt4, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_mul_controller #(.MUL_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .memToRegE(memToRegE), .ALUControlE(alu4), .branchTakenE(branchTakenE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .writeRegW(writeRegW), .regWriteW(regWriteW),
        .forwardAE(fa4), .forwardBE(fb4), .stallF(sf4), .stallD(sd4), .stallE(se4),
        .flushD(fd4), .flushE(fe4), .flushM(fm4), .mulBusy(mb4), .mulDone(md4), .stallCount(cnt4));

    hazard_mul_controller #(.MUL_CYCLES(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .memToRegE(memToRegE), .ALUControlE(alu2), .branchTakenE(branchTakenE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .writeRegW(writeRegW), .regWriteW(regWriteW),
        .forwardAE(fa2), .forwardBE(fb2), .stallF(sf2), .stallD(sd2), .stallE(se2),
        .flushD(fd2), .flushE(fe2), .flushM(fm2), .mulBusy(mb2), .mulDone(md2), .stallCount(cnt2));

    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e;
        logic       mem, br;
        logic [4:0] wr_m;
        logic       rw_m;
        logic [4:0] wr_w;
        logic       rw_w;
        logic [1:0] exp_fa, exp_fb;
        logic [5:0] exp_ctl;   // {stallF, stallD, stallE, flushD, flushE, flushM}
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        memToRegE = 1'b0; branchTakenE = 1'b0;
        writeRegM = 5'd0; regWriteM = 1'b0; writeRegW = 5'd0; regWriteW = 1'b0;
    endtask

    // Multiply-phase check for the MUL_CYCLES=4 instance.
    task automatic chk_mul4(input string name, input logic stall, input logic done);
        chk({name, " ctl4"}, {26'd0, sf4, sd4, se4, fd4, fe4, fm4}, {26'd0, stall, stall, stall, 1'b0, 1'b0, stall});
        chk({name, " busy4"}, {30'd0, mb4, md4}, {30'd0, stall, done});
    endtask

    task automatic chk_mul2(input string name, input logic stall, input logic done);
        chk({name, " ctl2"}, {26'd0, sf2, sd2, se2, fd2, fe2, fm2}, {26'd0, stall, stall, stall, 1'b0, 1'b0, stall});
        chk({name, " busy2"}, {30'd0, mb2, md2}, {30'd0, stall, done});
    endtask

    initial begin
        //          rsD    rtD    rsE    rtE    mem   br    wrM    rwM   wrW    rwW   fa     fb     ctl
        vecs[0]  = '{5'd0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};
        vecs[1]  = '{5'd0, 5'd0,  5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 2'b10, 2'b00, 6'b000000};
        vecs[2]  = '{5'd0, 5'd0,  5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 2'b01, 2'b00, 6'b000000};
        vecs[3]  = '{5'd0, 5'd0,  5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00, 6'b000000};
        vecs[4]  = '{5'd0, 5'd0,  5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b00, 2'b01, 6'b000000};
        vecs[5]  = '{5'd0, 5'd0,  5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 2'b10, 2'b10, 6'b000000};
        vecs[6]  = '{5'd8, 5'd0,  5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b110010};
        vecs[7]  = '{5'd1, 5'd8,  5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b110010};
        vecs[8]  = '{5'd0, 5'd0,  5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};
        vecs[9]  = '{5'd9, 5'd10, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};
        vecs[10] = '{5'd8, 5'd0,  5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000110};
        vecs[11] = '{5'd0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000110};

        // Reset asserted: outputs forced low even though forwarding would fire.
        rsE = 5'd9; writeRegM = 5'd9; regWriteM = 1'b1;
        #2;
        chk("reset fwdA", {30'd0, fa4}, 32'd0);
        chk("reset ctl", {26'd0, sf4, sd4, se4, fd4, fe4, fm4}, 32'd0);
        chk("reset cnt", {16'd0, cnt4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rsD = vecs[i].rs_d; rtD = vecs[i].rt_d; rsE = vecs[i].rs_e; rtE = vecs[i].rt_e;
            memToRegE = vecs[i].mem; branchTakenE = vecs[i].br;
            writeRegM = vecs[i].wr_m; regWriteM = vecs[i].rw_m;
            writeRegW = vecs[i].wr_w; regWriteW = vecs[i].rw_w;
            #3;
            chk($sformatf("vec%0d fwdA", i), {30'd0, fa4}, {30'd0, vecs[i].exp_fa});
            chk($sformatf("vec%0d fwdB", i), {30'd0, fb4}, {30'd0, vecs[i].exp_fb});
            chk($sformatf("vec%0d ctl", i), {26'd0, sf4, sd4, se4, fd4, fe4, fm4}, {26'd0, vecs[i].exp_ctl});
            chk($sformatf("vec%0d ctl2", i), {26'd0, sf2, sd2, se2, fd2, fe2, fm2}, {26'd0, vecs[i].exp_ctl});
        end
        @(posedge clk); #1;
        clear_inputs();
        #3;
        chk("table stallCount", {16'd0, cnt4}, 32'd2);

        // MUL_CYCLES=4, two back-to-back multiplies; load-use during BUSY must not flush E.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            alu4 = 4'b1111;
            if (i == 1) begin
                memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
            end else begin
                clear_inputs();
            end
            #3;
            chk_mul4($sformatf("mul4 c%0d", i), (i != 3) && (i != 7), (i == 3) || (i == 7));
        end
        @(posedge clk); #1;
        alu4 = 4'd0;
        clear_inputs();
        #3;
        chk_mul4("mul4 idle", 1'b0, 1'b0);
        chk("mul4 stallCount", {16'd0, cnt4}, 32'd8);

        // MUL_CYCLES=2: stall, done, then a back-to-back stall, done.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            alu2 = 4'b1111;
            #3;
            chk_mul2($sformatf("mul2 c%0d", i), (i == 0) || (i == 2), (i == 1) || (i == 3));
        end
        @(posedge clk); #1;
        alu2 = 4'd0;
        #3;
        chk_mul2("mul2 idle", 1'b0, 1'b0);
        chk("mul2 stallCount", {16'd0, cnt2}, 32'd5);

        // Asynchronous reset while the multiply sits in BUSY.
        @(posedge clk); #1;
        alu4 = 4'b1111; rsE = 5'd9; writeRegM = 5'd9; regWriteM = 1'b1;
        #3;
        chk("rst pre busy", {31'd0, mb4}, 32'd1);
        @(posedge clk); #1;
        #2;
        chk("rst in busy", {31'd0, mb4}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async ctl", {22'd0, fa4, fb4, sf4, sd4, se4, fd4, fe4, fm4, mb4, md4}, 32'd0);
        chk("rst async cnt", {16'd0, cnt4}, 32'd0);
        @(posedge clk); #1;
        alu4 = 4'd0;
        rst_n = 1'b1;
        #3;
        chk("rst release busy", {30'd0, mb4, md4}, 32'd0);
        chk("rst release cnt", {16'd0, cnt4}, 32'd0);
        chk("rst release fwdA", {30'd0, fa4}, 32'd2);
        @(posedge clk); #3;
        chk("rst idle cnt", {16'd0, cnt4}, 32'd0);
        chk("rst idle cnt2", {16'd0, cnt2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_mul_controller.md
Name: hazard_mul_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS datapath driven by the decode control unit.
- Generates data forwarding selects, load-use stalls and branch flushes.
- Sequences the multi-cycle multiply (ALU control 4'b1111) by holding F/D/E and bubbling M until the multiplier completes.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MUL_CYCLES, 4, total EX-stage occupancy of a multiply in cycles; legal range 2..255.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rsD  input  5  decode-stage source register rs
rtD  input  5  decode-stage source register rt
rsE  input  5  execute-stage rs
rtE  input  5  execute-stage rt
memToRegE  input  1  EX instruction is a load
ALUControlE  input  4  EX ALU control; bubbles carry 4'b0000
branchTakenE  input  1  branch/BNE resolved taken in EX
writeRegM  input  5  MEM destination register
regWriteM  input  1  MEM writes register file
writeRegW  input  5  WB destination register
regWriteW  input  1  WB writes register file
forwardAE  output  2  ALU operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
forwardBE  output  2  ALU operand B select, same encoding
stallF  output  1  hold PC
stallD  output  1  hold IF/ID register
stallE  output  1  hold ID/EX register
flushD  output  1  clear IF/ID register
flushE  output  1  clear ID/EX register
flushM  output  1  insert bubble into EX/MEM register
mulBusy  output  1  multiply sequencing in progress
mulDone  output  1  final multiply cycle; result valid on ALU output
stallCount  output  CNT_W  number of cycles with stallF=1, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): FSM to IDLE, internal counter 0, stallCount 0. While reset is asserted, all outputs are forced to 0.
- Forwarding (combinational):
  - forwardAE=10 if regWriteM && writeRegM!=0 && writeRegM==rsE.
  - Otherwise forwardAE=01 if regWriteW && writeRegW!=0 && writeRegW==rsE.
  - Otherwise 00.
  - forwardBE uses rtE with the same rules. MEM has priority over WB.
- Load-use (combinational): lwStall = memToRegE && rtE!=0 && (rtE==rsD || rtE==rtD).
  - Produces stallF=stallD=1 and flushE=1 for one cycle per occurrence.
- Branch: branchTakenE=1 gives flushD=flushE=1, with stallF=stallD=0 and the PC redirected.
  - Branch has priority over lwStall in the same cycle.
- Multiply FSM states: IDLE, BUSY, DONE.
  - mulE = (ALUControlE==4'b1111).
  - IDLE with mulE: stallF=stallD=stallE=1, flushM=1, mulBusy=1.
    - If MUL_CYCLES==2, next state is DONE.
    - Otherwise next state is BUSY with cnt <= MUL_CYCLES-3.
  - BUSY: stallF=stallD=stallE=1, flushM=1, mulBusy=1.
    - cnt==0: next state DONE. Otherwise cnt <= cnt-1.
  - DONE: no stalls, mulDone=1, mulBusy=0. mulE is ignored in this cycle (no retrigger on the same instruction). Next state IDLE.
  - Total EX occupancy is exactly MUL_CYCLES cycles. A back-to-back multiply enters EX the cycle after DONE and retriggers from IDLE.
- Priority:
  - Multiply (IDLE-with-mulE or BUSY) overrides lwStall.
  - flushE is suppressed while stallE=1.
  - A branch cannot be in EX while a multiply is, so branchTakenE cannot coincide with a multiply.
- stallCount: increments on each rising edge where stallF=1; holds at all-ones.
- Reset mid-multiply: returns to IDLE. The in-flight instruction is discarded by the pipeline reset.

Test Plan:
- Load-use: lw $t0 in EX (memToRegE=1, rtE=8), rsD=8 -> one cycle of stallF=stallD=flushE=1, then release; stallCount=1.
- Forwarding: regWriteM=1, writeRegM=9 and regWriteW=1, writeRegW=9, rsE=9 -> forwardAE=10. Then writeRegM=0 -> forwardAE=01. rtE=0 with writeRegW=0 -> forwardBE=00.
- Branch vs load-use same cycle: branchTakenE=1 and lwStall=1 -> flushD=flushE=1, stallF=stallD=0.
- Multiply, MUL_CYCLES=4: ALUControlE=4'b1111 -> stallF/D/E and flushM high for 3 cycles, mulDone=1 on cycle 4, stallCount=3. Back-to-back multiply gives 3 more stall cycles.
- MUL_CYCLES=2: mulE -> 1 stall cycle, then DONE, then IDLE.
- Reset during BUSY: rst_n=0 -> all outputs 0 immediately (asynchronous). After release, mulBusy=0 and stallCount=0.
